// File: rtl/exec_unit.sv
// -----------------------------------------------------------------------------
// exec_unit -- integer execution unit with a valid/ready handshake on both
// sides. Single-cycle ALU ops return their result one cycle after accept;
// MUL (shift-add) and REM (signed, restoring) iterate one bit per cycle and
// return their result 33 cycles after accept.
//
// Ports
//   clk        sole clock, rising edge
//   reset      synchronous, active-low
//   flush      synchronous abort of any in-flight operation
//   in_valid   operation offered          in_ready   operation accepted
//   alu_op     inst_pkg::alu_op_e code    op_a/op_b  operands (op_a = PC for AUIPC)
//   in_rd      destination tag
//   out_valid  result available           out_ready  consumer takes result
//   result     operation result           out_rd     tag of the result
// -----------------------------------------------------------------------------
package inst_pkg;
    typedef enum logic [4:0] {
        OP_NOP   = 5'd0,
        OP_ADD   = 5'd1,
        OP_SUB   = 5'd2,
        OP_XOR   = 5'd3,
        OP_OR    = 5'd4,
        OP_AND   = 5'd5,
        OP_SHL   = 5'd6,
        OP_SHR   = 5'd7,
        OP_SHRU  = 5'd8,
        OP_SLT   = 5'd9,
        OP_SLTU  = 5'd10,
        OP_AUIPC = 5'd11,
        OP_MUL   = 5'd12,
        OP_REM   = 5'd13
    } alu_op_e;
endpackage

module exec_unit
    import inst_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      alu_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [4:0]      out_rd
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        REM_BUSY = 2'd2
    } state_e;

    state_e          state_q, state_d;
    alu_op_e         op_sel;
    logic [5:0]      cnt_q;          // iterations done, saturates at 32
    logic [XLEN-1:0] x_q;            // multiplicand / dividend, shifts left
    logic [XLEN-1:0] y_q;            // multiplier (shifts right) / divisor
    logic [XLEN-1:0] acc_q;          // partial product / partial remainder
    logic            neg_q;          // REM result takes the sign of op_a
    logic [4:0]      rd_q;

    logic            accept;
    logic            alu_single;
    logic [XLEN-1:0] alu_res;
    logic            step;
    logic            last_step;
    logic [XLEN-1:0] mul_acc_nxt;
    logic [XLEN-1:0] rem_shift;
    logic [XLEN-1:0] rem_nxt;
    logic [XLEN-1:0] iter_res;

    assign op_sel = alu_op_e'(alu_op);

    // Gating with reset and flush keeps in_ready honest: the producer never
    // sees a handshake that the unit is about to ignore.
    assign in_ready = reset && !flush && (state_q == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Single-cycle ALU. SHRU is the sign-filling shift (funct7[5]=1 decode).
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the case leaves it unassigned and infers a latch.
        alu_res    = '0;
        alu_single = 1'b1;
        case (op_sel)
            OP_ADD, OP_AUIPC: alu_res = op_a + op_b;
            OP_SUB:           alu_res = op_a - op_b;
            OP_XOR:           alu_res = op_a ^ op_b;
            OP_OR:            alu_res = op_a | op_b;
            OP_AND:           alu_res = op_a & op_b;
            OP_SHL:           alu_res = op_a << op_b[4:0];
            OP_SHR:           alu_res = op_a >> op_b[4:0];
            OP_SHRU:          alu_res = $unsigned($signed(op_a) >>> op_b[4:0]);
            OP_SLT:           alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            OP_SLTU:          alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            default:          alu_single = 1'b0;
        endcase
    end

    // One iteration of each multi-cycle algorithm.
    always_comb begin
        mul_acc_nxt = y_q[0] ? acc_q + x_q : acc_q;
        rem_shift   = {acc_q[XLEN-2:0], x_q[XLEN-1]};
        rem_nxt     = (rem_shift >= y_q) ? rem_shift - y_q : rem_shift;
        iter_res    = (state_q == MUL_BUSY) ? mul_acc_nxt
                    : (neg_q ? -rem_nxt : rem_nxt);
    end

    // Iterations run while busy and below 32; the cycle with cnt_q==32 is the
    // one in which the result is first visible, and the FSM leaves busy then.
    assign step      = (state_q != IDLE) && (cnt_q < 6'd32);
    assign last_step = step && (cnt_q == 6'd31);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && op_sel == OP_MUL)      state_d = MUL_BUSY;
                else if (accept && op_sel == OP_REM) state_d = REM_BUSY;
            end
            MUL_BUSY, REM_BUSY: begin
                if (cnt_q == 6'd32) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            rd_q      <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            out_rd    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            cnt_q     <= '0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;

            if (accept) begin
                rd_q  <= in_rd;
                cnt_q <= '0;
                acc_q <= '0;
                if (op_sel == OP_REM) begin
                    // Restoring division works on magnitudes; 0x8000_0000
                    // stays 0x8000_0000 which is its correct unsigned magnitude.
                    x_q   <= op_a[XLEN-1] ? -op_a : op_a;
                    y_q   <= op_b[XLEN-1] ? -op_b : op_b;
                    neg_q <= op_a[XLEN-1];
                end else begin
                    x_q   <= op_a;
                    y_q   <= op_b;
                    neg_q <= 1'b0;
                end
                if (alu_single) begin
                    result    <= alu_res;
                    out_rd    <= in_rd;
                    out_valid <= 1'b1;
                end
            end else if (step) begin
                cnt_q <= cnt_q + 6'd1;
                x_q   <= x_q << 1;
                if (state_q == MUL_BUSY) begin
                    acc_q <= mul_acc_nxt;
                    y_q   <= y_q >> 1;
                end else begin
                    acc_q <= rem_nxt;
                end
                if (last_step) begin
                    result    <= iter_res;
                    out_rd    <= rd_q;
                    out_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit. Inputs change on the falling edge and
// outputs are sampled 1 ns later, so each sample shows the current cycle.
module tb_exec_unit;
    import inst_pkg::*;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [4:0]  alu_op, in_rd, out_rd;
    logic [31:0] op_a, op_b, result;

    int checks   = 0;
    int failures = 0;

    exec_unit #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .op_a(op_a), .op_b(op_b), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .out_rd(out_rd)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step_clk();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference: result and latency from the arithmetic definition of each op.
    task automatic model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] r);
        logic [63:0] prod;
        int          sa, sb;
        int          sh;
        sh  = int'(b[4:0]);
        lat = 1;
        r   = '0;
        case (op)
            OP_ADD, OP_AUIPC: r = a + b;
            OP_SUB:  r = a - b;
            OP_XOR:  r = a ^ b;
            OP_OR:   r = a | b;
            OP_AND:  r = a & b;
            OP_SHL:  r = a << sh;
            OP_SHR:  r = a >> sh;
            OP_SHRU: r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            OP_SLT:  begin sa = a; sb = b; r = (sa < sb) ? 32'd1 : 32'd0; end
            OP_SLTU: r = (a < b) ? 32'd1 : 32'd0;
            OP_MUL:  begin prod = {32'h0, a} * {32'h0, b}; r = prod[31:0]; lat = 33; end
            OP_REM: begin
                lat = 33;
                sa  = a;
                sb  = b;
                if (b == 32'h0)                                 r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
                else                                            r = sa % sb;
            end
            default: lat = 0;
        endcase
    endtask

    // Issue one op with out_ready=1 and check latency, busy in_ready, result, tag.
    task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        int          exp_lat, lat, busy_bad;
        logic [31:0] exp_r;
        model(op, a, b, exp_lat, exp_r);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        alu_op    = op;
        op_a      = a;
        op_b      = b;
        in_rd     = rd;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL accept_ready op=%0d: in_ready=%b want 1", op, in_ready);
        end
        step_clk();
        in_valid = 1'b0;
        if (exp_lat == 0) begin
            busy_bad = 0;
            for (int i = 0; i < 3; i++) begin
                #1;
                if (out_valid !== 1'b0) busy_bad++;
                step_clk();
            end
            checks++;
            if (busy_bad != 0) begin
                failures++;
                $display("FAIL no_output op=%0d: out_valid high %0d cycles want 0", op, busy_bad);
            end
            return;
        end
        lat      = 1;
        busy_bad = 0;
        while (1) begin
            #1;
            if (exp_lat > 1 && in_ready !== 1'b0) busy_bad++;
            if (out_valid === 1'b1 || lat >= 40) break;
            step_clk();
            lat++;
        end
        checks++;
        if (lat != exp_lat || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL latency op=%0d: got %0d (out_valid=%b) want %0d", op, lat, out_valid, exp_lat);
        end
        checks++;
        if (result !== exp_r || out_rd !== rd) begin
            failures++;
            $display("FAIL result op=%0d a=%h b=%h: got %h rd=%0d want %h rd=%0d",
                     op, a, b, result, out_rd, exp_r, rd);
        end
        if (exp_lat > 1) begin
            checks++;
            if (busy_bad != 0) begin
                failures++;
                $display("FAIL busy_ready op=%0d: in_ready high %0d busy cycles want 0", op, busy_bad);
            end
        end
        step_clk();
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain op=%0d: out_valid=%b want 0", op, out_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alu_op = '0; op_a = '0; op_b = '0; in_rd = '0;
        step_clk();
        step_clk();
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || result !== 32'h0 || out_rd !== 5'h0) begin
            failures++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b result=%h out_rd=%0d want 0 0 0 0",
                     in_ready, out_valid, result, out_rd);
        end
        step_clk();
        reset = 1'b1;
        step_clk();
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release: in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic test_directed_alu();
        do_op(OP_ADD,  32'h7FFF_FFFF, 32'h1, 5'd5);
        do_op(OP_SHRU, 32'h8000_0000, 32'd4, 5'd6);
        do_op(OP_SHR,  32'h8000_0000, 32'd4, 5'd7);
        do_op(OP_SLT,  32'hFFFF_FFFF, 32'd1, 5'd8);
        do_op(OP_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd9);
        do_op(OP_NOP,  32'h1234_5678, 32'd1, 5'd10);
    endtask

    task automatic test_mul();
        do_op(OP_MUL, 32'hFFFF_FFFF, 32'd3, 5'd11);
        do_op(OP_MUL, 32'h0001_0003, 32'h0002_0005, 5'd12);
    endtask

    task automatic test_rem();
        do_op(OP_REM, 32'hFFFF_FFF9, 32'd3, 5'd13);
        do_op(OP_REM, 32'd7, 32'd0, 5'd14);
        do_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15);
        do_op(OP_REM, 32'd100, 32'hFFFF_FFF9, 5'd16);
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic [4:0]  op;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       a = 32'h8000_0000;
                1:       a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            b  = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
            op = 5'($urandom_range(0, 16));
            do_op(op, a, b, 5'($urandom));
        end
    endtask

    task automatic test_backpressure();
        int          bad;
        logic [31:0] exp_add, exp_sub;
        exp_add   = 32'h1111_2222 + 32'h0F0F_0F0F;
        exp_sub   = 32'h0000_0010 - 32'h0000_0020;
        out_ready = 1'b0;
        in_valid  = 1'b1; alu_op = OP_ADD; op_a = 32'h1111_2222; op_b = 32'h0F0F_0F0F; in_rd = 5'd20;
        step_clk();
        in_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (out_valid !== 1'b1 || result !== exp_add || out_rd !== 5'd20 || in_ready !== 1'b0) bad++;
            step_clk();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL stall_hold: %0d of 5 stalled cycles wrong (result=%h want %h)", bad, result, exp_add);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1; alu_op = OP_SUB; op_a = 32'h10; op_b = 32'h20; in_rd = 5'd21;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL drain_accept: in_ready=%b out_valid=%b want 1 1", in_ready, out_valid);
        end
        step_clk();
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || result !== exp_sub || out_rd !== 5'd21) begin
            failures++;
            $display("FAIL back_to_back: out_valid=%b result=%h rd=%0d want 1 %h 21",
                     out_valid, result, out_rd, exp_sub);
        end
        step_clk();
    endtask

    // Start a MUL at cycle N and stop at cycle N+10 with flush or reset.
    task automatic test_abort(input bit use_reset);
        int bad;
        out_ready = 1'b1;
        in_valid  = 1'b1; alu_op = OP_MUL; op_a = 32'h1234_5678; op_b = 32'h9; in_rd = 5'd22;
        step_clk();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) step_clk();
        if (use_reset) begin
            reset = 1'b0;
            step_clk();
            #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0 || result !== 32'h0 || out_rd !== 5'h0) begin
                failures++;
                $display("FAIL reset_abort_outputs: in_ready=%b out_valid=%b result=%h out_rd=%0d want 0 0 0 0",
                         in_ready, out_valid, result, out_rd);
            end
            reset = 1'b1;
        end else begin
            flush = 1'b1;
            step_clk();
            flush = 1'b0;
        end
        if (use_reset) step_clk();
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_ready reset=%0d: in_ready=%b out_valid=%b want 1 0",
                     use_reset, in_ready, out_valid);
        end
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            step_clk();
            #1;
            if (out_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL abort_no_result reset=%0d: out_valid high %0d cycles want 0", use_reset, bad);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_directed_alu();
        test_mul();
        test_rem();
        test_backpressure();
        test_random();
        test_abort(1'b0);
        do_op(OP_SUB, 32'hDEAD_BEEF, 32'h1, 5'd3);
        test_abort(1'b1);
        do_op(OP_XOR, 32'hA5A5_A5A5, 32'hFFFF_0000, 5'd4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
